// File: rtl/uart_core_param_if.sv
// uart_core_param_if: system-side TX/RX word interface of the UART core
// Ports: master = system side (drives tx_valid/tx_data), slave = UART core
//   tx_valid/tx_ready/tx_data : TX word handshake into the TX FIFO
//   tx_busy                   : FIFO non-empty or frame in progress
//   rx_data/rx_valid          : received word, one-cycle valid pulse
//   rx_parity_err/rx_frame_err: error flags qualified by rx_valid
interface uart_core_param_if #(parameter int DATA_BITS = 8);
  logic tx_valid, tx_ready, tx_busy;
  logic [DATA_BITS-1:0] tx_data, rx_data;
  logic rx_valid, rx_parity_err, rx_frame_err;
  modport master(output tx_valid, tx_data, input tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err);
  modport slave(input tx_valid, tx_data, output tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err);
endinterface

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised UART with TX FIFO, RX synchroniser, parity and framing checks
// Ports: clk, rst (async active-low), bus (uart_core_param_if.slave word interface),
//   tx (registered serial out, idles high), rx (async serial in),
//   loopback (only when UART_LOOPBACK_EN is defined: 1 routes the tx register into RX)
module uart_core_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH = 4
) (
  input logic clk,
  input logic rst,
`ifdef UART_LOOPBACK_EN
  input logic loopback,
`endif
  uart_core_param_if.slave bus,
  output logic tx,
  input logic rx
);
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  logic [DATA_BITS-1:0] mem [TX_DEPTH];
  logic [AW:0] wp, rp;
  logic armed, empty, full, push, pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign bus.tx_ready = armed && !full;
  assign push = bus.tx_valid && bus.tx_ready;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= bus.tx_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (push) wp <= wp + 1'b1;
    end
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  tx_state_t ts;
  logic [CW-1:0] tcnt;
  logic [BW-1:0] tbit;
  logic [DATA_BITS-1:0] tsh;
  logic tpar;
  // STOP hands straight over to START when another word is queued, so frames abut
  assign pop = !empty && (ts == T_IDLE || (ts == T_STOP && tcnt == STOP_END));
  assign bus.tx_busy = !empty || ts != T_IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ts <= T_IDLE;
      tcnt <= '0;
      tbit <= '0;
      tsh <= '0;
      tpar <= 1'b0;
      rp <= '0;
      tx <= 1'b1;
    end else begin
      // tx lags the state by one cycle, giving the two-edge push-to-start latency
      tx <= ts == T_START ? 1'b0 : ts == T_DATA ? tsh[0] : ts == T_PAR ? tpar : 1'b1;
      tcnt <= tcnt + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        tsh <= mem[rp[AW-1:0]];
        tpar <= PARITY == 1 ? ~^mem[rp[AW-1:0]] : ^mem[rp[AW-1:0]];
        ts <= T_START;
        tcnt <= '0;
      end else begin
        case (ts)
          T_IDLE: tcnt <= '0;
          T_START: if (tcnt == BIT_END) begin
            ts <= T_DATA;
            tcnt <= '0;
            tbit <= '0;
          end
          T_DATA: if (tcnt == BIT_END) begin
            tcnt <= '0;
            tsh <= tsh >> 1;
            tbit <= tbit == LAST_BIT ? '0 : tbit + 1'b1;
            if (tbit == LAST_BIT) ts <= PARITY != 0 ? T_PAR : T_STOP;
          end
          T_PAR: if (tcnt == BIT_END) begin
            ts <= T_STOP;
            tcnt <= '0;
          end
          T_STOP: if (tcnt == STOP_END) begin
            ts <= T_IDLE;
            tcnt <= '0;
          end
          default: ts <= T_IDLE;
        endcase
      end
    end
  logic rx_in, s1, s2;
`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx : rx;
`else
  assign rx_in = rx;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rx_in;
      s2 <= s1;
    end
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;
  rx_state_t rs;
  logic [CW-1:0] rcnt;
  logic [BW-1:0] rbit;
  logic [DATA_BITS-1:0] rsh, rdata;
  logic rpar, rv, pe, fe;
  assign bus.rx_data = rdata;
  assign bus.rx_valid = rv;
  assign bus.rx_parity_err = pe;
  assign bus.rx_frame_err = fe;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rs <= R_IDLE;
      rcnt <= '0;
      rbit <= '0;
      rsh <= '0;
      rpar <= 1'b0;
      rdata <= '0;
      rv <= 1'b0;
      pe <= 1'b0;
      fe <= 1'b0;
    end else begin
      rv <= 1'b0;
      pe <= 1'b0;
      fe <= 1'b0;
      rcnt <= rcnt + 1'b1;
      case (rs)
        R_IDLE: begin
          rcnt <= '0;
          if (!s2) rs <= R_START;
        end
        // recheck at the start-bit centre; a high line here was a glitch
        R_START: if (rcnt == HALF_END) begin
          rcnt <= '0;
          rbit <= '0;
          rs <= s2 ? R_IDLE : R_DATA;
        end
        R_DATA: if (rcnt == BIT_END) begin
          rcnt <= '0;
          rsh <= {s2, rsh[DATA_BITS-1:1]};
          rbit <= rbit == LAST_BIT ? '0 : rbit + 1'b1;
          if (rbit == LAST_BIT) rs <= PARITY != 0 ? R_PAR : R_STOP;
        end
        R_PAR: if (rcnt == BIT_END) begin
          rcnt <= '0;
          rpar <= s2;
          rs <= R_STOP;
        end
        R_STOP: if (rcnt == BIT_END) begin
          rcnt <= '0;
          rv <= 1'b1;
          rdata <= rsh;
          pe <= PARITY != 0 && (rpar != (PARITY == 1 ? ~^rsh : ^rsh));
          fe <= !s2;
          rs <= s2 ? R_IDLE : R_WAIT;
        end
        // a low stop bit may be a break; re-arm only once the line is high again
        R_WAIT: begin
          rcnt <= '0;
          if (s2) rs <= R_IDLE;
        end
        default: rs <= R_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: directed self-checking bench for uart_core_param (8 data, even parity, 1 stop)
module tb_uart_core_param;
  logic clk = 1'b0, rst = 1'b0, rx = 1'b1, tx;
`ifdef UART_LOOPBACK_EN
  logic loopback = 1'b0;
`endif
  int errors = 0, checks = 0, vcnt = 0;
  logic [7:0] cap_data = '0;
  logic cap_pe = 1'b0, cap_fe = 1'b0;
  uart_core_param_if #(.DATA_BITS(8)) bus();
  uart_core_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .TX_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef UART_LOOPBACK_EN
    .loopback(loopback),
`endif
    .bus(bus),
    .tx(tx),
    .rx(rx)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.rx_valid === 1'b1) begin
      vcnt++;
      cap_data = bus.rx_data;
      cap_pe = bus.rx_parity_err;
      cap_fe = bus.rx_frame_err;
    end
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_rx(input logic [7:0] d, input logic p, input logic s, input int hold);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(16);
    end
    rx = p;
    tick(16);
    rx = s;
    tick(hold);
    rx = 1'b1;
    tick(16);
  endtask
  task automatic test_reset;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    tick(3);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", tx); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bus.tx_ready); end
    checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.tx_busy); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b want=0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h want=00", bus.rx_data); end
    checks++; if ({bus.rx_parity_err, bus.rx_frame_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {bus.rx_parity_err, bus.rx_frame_err}); end
    rst = 1'b1;
    #1;
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got=%b want=0", bus.tx_ready); end
    tick(1);
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got=%b want=1", bus.tx_ready); end
  endtask
  task automatic test_tx_single;
    logic [10:0] f;
    f = {1'b1, 1'b0, 8'hA5, 1'b0};
    bus.tx_data = 8'hA5;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_latency_n got=%b want=1", tx); end
    tick(1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_latency_n1 got=%b want=1", tx); end
    tick(1);
    for (int c = 0; c < 176; c++) begin
      checks++; if (tx !== f[c / 16]) begin errors++; $display("FAIL tx_a5_cycle%0d got=%b want=%b", c, tx, f[c / 16]); end
      if (c == 88) begin
        checks++; if (bus.tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_mid got=%b want=1", bus.tx_busy); end
      end
      tick(1);
    end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_after_frame got=%b want=1", tx); end
    checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_end got=%b want=0", bus.tx_busy); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] d [6];
    logic pb [5];
    logic [10:0] fr;
    logic want;
    int acc;
    d = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h96, 8'h55};
    pb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    acc = 0;
    for (int k = 0; k < 884; k++) begin
      if (k < 6) begin
        bus.tx_data = d[k];
        bus.tx_valid = 1'b1;
        checks++; if (bus.tx_ready !== (k < 5)) begin errors++; $display("FAIL b2b_ready%0d got=%b want=%b", k, bus.tx_ready, k < 5); end
        if (bus.tx_ready === 1'b1) acc++;
      end else bus.tx_valid = 1'b0;
      if (k < 3 || k >= 883) want = 1'b1;
      else begin
        fr = {1'b1, pb[(k - 3) / 176], d[(k - 3) / 176], 1'b0};
        want = fr[((k - 3) % 176) / 16];
      end
      checks++; if (tx !== want) begin errors++; $display("FAIL b2b_tx_cycle%0d got=%b want=%b", k, tx, want); end
      tick(1);
    end
    checks++; if (acc !== 5) begin errors++; $display("FAIL b2b_accepted got=%0d want=5", acc); end
    checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b want=0", bus.tx_busy); end
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL tx_rx_independent got=%0d want=0", vcnt); end
  endtask
  task automatic test_rx_good;
    int base;
    base = vcnt;
    send_rx(8'h3C, 1'b0, 1'b1, 16);
    tick(20);
    checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL rx_good_pulses got=%0d want=1", vcnt - base); end
    checks++; if (cap_data !== 8'h3C) begin errors++; $display("FAIL rx_good_data got=%h want=3c", cap_data); end
    checks++; if ({cap_pe, cap_fe} !== 2'b00) begin errors++; $display("FAIL rx_good_flags got=%b want=00", {cap_pe, cap_fe}); end
  endtask
  task automatic test_rx_parity;
    int base;
    base = vcnt;
    send_rx(8'h3C, 1'b1, 1'b1, 16);
    tick(20);
    checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL rx_par_pulses got=%0d want=1", vcnt - base); end
    checks++; if (cap_data !== 8'h3C) begin errors++; $display("FAIL rx_par_data got=%h want=3c", cap_data); end
    checks++; if ({cap_pe, cap_fe} !== 2'b10) begin errors++; $display("FAIL rx_par_flags got=%b want=10", {cap_pe, cap_fe}); end
    checks++; if (bus.rx_parity_err !== 1'b0) begin errors++; $display("FAIL rx_par_idle_flag got=%b want=0", bus.rx_parity_err); end
  endtask
  task automatic test_rx_break;
    int base;
    base = vcnt;
    send_rx(8'h3C, 1'b0, 1'b0, 200);
    tick(40);
    checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL rx_brk_pulses got=%0d want=1", vcnt - base); end
    checks++; if (cap_data !== 8'h3C) begin errors++; $display("FAIL rx_brk_data got=%h want=3c", cap_data); end
    checks++; if ({cap_pe, cap_fe} !== 2'b01) begin errors++; $display("FAIL rx_brk_flags got=%b want=01", {cap_pe, cap_fe}); end
    send_rx(8'hC3, 1'b0, 1'b1, 16);
    tick(20);
    checks++; if (vcnt - base !== 2) begin errors++; $display("FAIL rx_rearm_pulses got=%0d want=2", vcnt - base); end
    checks++; if (cap_data !== 8'hC3) begin errors++; $display("FAIL rx_rearm_data got=%h want=c3", cap_data); end
    checks++; if ({cap_pe, cap_fe} !== 2'b00) begin errors++; $display("FAIL rx_rearm_flags got=%b want=00", {cap_pe, cap_fe}); end
  endtask
  task automatic test_glitch;
    int base;
    base = vcnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(200);
    checks++; if (vcnt - base !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d want=0", vcnt - base); end
  endtask
  task automatic test_reset_midframe;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b1;
    tick(2);
    bus.tx_valid = 1'b0;
    tick(38);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_data_low got=%b want=0", tx); end
    #3 rst = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx got=%b want=1", tx); end
    checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b want=0", bus.tx_busy); end
    tick(2);
    rst = 1'b1;
    tick(1);
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rerelease_ready got=%b want=1", bus.tx_ready); end
    checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL rerelease_fifo_empty got=%b want=0", bus.tx_busy); end
    tick(200);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rerelease_tx_idle got=%b want=1", tx); end
  endtask
`ifdef UART_LOOPBACK_EN
  task automatic test_loopback;
    int base;
    base = vcnt;
    loopback = 1'b1;
    bus.tx_data = 8'h5A;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    tick(200);
    loopback = 1'b0;
    checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL loop_pulses got=%0d want=1", vcnt - base); end
    checks++; if (cap_data !== 8'h5A) begin errors++; $display("FAIL loop_data got=%h want=5a", cap_data); end
    checks++; if ({cap_pe, cap_fe} !== 2'b00) begin errors++; $display("FAIL loop_flags got=%b want=00", {cap_pe, cap_fe}); end
  endtask
`endif
  initial begin
    test_reset;
    test_tx_single;
    test_back_to_back;
    test_rx_good;
    test_rx_parity;
    test_rx_break;
    test_glitch;
    test_reset_midframe;
`ifdef UART_LOOPBACK_EN
    test_loopback;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
